// File: rtl/traffic_sequencer_if.sv
// Signal bundle between the traffic sequencer and its consumers:
// the pedestrian request input and the phase/colour outputs.
interface traffic_sequencer_if #(
    parameter int CW = 4
);
    logic          pedestrian;
    logic [1:0]    currColour;
    logic [CW-1:0] phase_count;
    logic          phase_start;
    logic          walk;
    logic          ped_pending;

    modport master (
        output pedestrian,
        input  currColour, phase_count, phase_start, walk, ped_pending
    );

    modport slave (
        input  pedestrian,
        output currColour, phase_count, phase_start, walk, ped_pending
    );
endinterface

// File: rtl/traffic_sequencer.sv
// Junction light phase sequencer: RED -> GREEN -> AMBER -> RED with per-phase
// durations; a latched pedestrian request cuts GREEN short to MIN_GREEN cycles.
module traffic_sequencer #(
    parameter int RED_TICKS   = 10,
    parameter int GREEN_TICKS = 8,
    parameter int AMBER_TICKS = 4,
    parameter int MIN_GREEN   = 3,
    parameter int CW          = 4
) (
    input  logic second_clk,
    input  logic reset,
    traffic_sequencer_if.slave tl
);
    typedef enum logic [1:0] {
        RED   = 2'b00,
        AMBER = 2'b01,
        GREEN = 2'b11
    } state_t;

    localparam logic [CW-1:0] RED_LAST   = CW'(RED_TICKS - 1);
    localparam logic [CW-1:0] GREEN_LAST = CW'(GREEN_TICKS - 1);
    localparam logic [CW-1:0] AMBER_LAST = CW'(AMBER_TICKS - 1);
    localparam logic [CW-1:0] MIN_LAST   = CW'(MIN_GREEN - 1);

    state_t        r_state, w_state_nxt;
    logic [CW-1:0] r_count, w_count_nxt;
    logic          r_ped, w_ped_nxt;
    logic          w_phase_end;

    always_ff @(posedge second_clk) begin
        if (reset) begin
            r_state <= RED;
            r_count <= '0;
            r_ped   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_count <= w_count_nxt;
            r_ped   <= w_ped_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_phase_end = 1'b0;
        case (r_state)
            RED: begin
                if (r_count == RED_LAST) begin
                    w_phase_end = 1'b1;
                    w_state_nxt = GREEN;
                end
            end
            GREEN: begin
                // Shortening uses the registered request only.
                if (r_count == GREEN_LAST || (r_ped && r_count >= MIN_LAST)) begin
                    w_phase_end = 1'b1;
                    w_state_nxt = AMBER;
                end
            end
            AMBER: begin
                if (r_count == AMBER_LAST) begin
                    w_phase_end = 1'b1;
                    w_state_nxt = RED;
                end
            end
            default: begin
                w_phase_end = 1'b1;
                w_state_nxt = RED;
            end
        endcase

        w_count_nxt = w_phase_end ? '0 : r_count + CW'(1);

        // RED already serves pedestrians, so requests there are dropped and
        // entering RED clears any pending one, overriding a same-cycle set.
        w_ped_nxt = r_ped;
        if (r_state != RED && tl.pedestrian)
            w_ped_nxt = 1'b1;
        if (r_state != RED && w_state_nxt == RED)
            w_ped_nxt = 1'b0;
    end

    assign tl.currColour  = r_state;
    assign tl.phase_count = r_count;
    assign tl.phase_start = (r_count == '0);
    assign tl.walk        = (r_state == RED);
    assign tl.ped_pending = r_ped;
endmodule

// File: tb/tb_traffic_sequencer.sv
// Directed bench for traffic_sequencer: nominal cycle, pedestrian shortening,
// late requests, requests during RED, mid-phase reset and a held request.
module tb_traffic_sequencer;
    localparam logic [1:0] C_RED   = 2'b00;
    localparam logic [1:0] C_GREEN = 2'b11;
    localparam logic [1:0] C_AMBER = 2'b01;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    traffic_sequencer_if #(.CW(4)) tl ();

    traffic_sequencer #(
        .RED_TICKS(10), .GREEN_TICKS(8), .AMBER_TICKS(4), .MIN_GREEN(3), .CW(4)
    ) dut (
        .second_clk (clk),
        .reset      (rst),
        .tl         (tl)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Checks counts first..last of a phase, advancing one cycle after each.
    task automatic expect_phase(input string tag, input logic [1:0] col,
                                input int first, input int last, input int ped);
        for (int c = first; c <= last; c++) begin
            chk({tag, "_col"},  32'(tl.currColour),  32'(col));
            chk({tag, "_cnt"},  32'(tl.phase_count), 32'(c));
            chk({tag, "_ps"},   32'(tl.phase_start), (c == 0) ? 32'd1 : 32'd0);
            chk({tag, "_walk"}, 32'(tl.walk),        (col == C_RED) ? 32'd1 : 32'd0);
            if (ped >= 0)
                chk({tag, "_ped"}, 32'(tl.ped_pending), 32'(ped));
            tick();
        end
    endtask

    initial begin
        tl.pedestrian = 1'b0;
        rst = 1'b1;

        // Reset values, and held while reset stays high
        tick();
        expect_phase("rst0", C_RED, 0, 0, 0);
        expect_phase("rst1", C_RED, 0, 0, 0);
        rst = 1'b0;

        // 1: nominal 22-cycle loop
        expect_phase("t1r", C_RED,   0, 9, 0);
        expect_phase("t1g", C_GREEN, 0, 7, 0);
        expect_phase("t1a", C_AMBER, 0, 3, 0);
        expect_phase("t1r2", C_RED,  0, 9, 0);

        // 2: pulse at GREEN count 0 -> GREEN is 3 cycles
        tl.pedestrian = 1'b1;
        expect_phase("t2g0", C_GREEN, 0, 0, 0);
        tl.pedestrian = 1'b0;
        expect_phase("t2g",  C_GREEN, 1, 2, 1);
        expect_phase("t2a",  C_AMBER, 0, 3, 1);
        expect_phase("t2r",  C_RED,   0, 9, 0);

        // 3: pulse at GREEN count 7 -> full GREEN, pending through AMBER
        expect_phase("t3g",  C_GREEN, 0, 6, 0);
        tl.pedestrian = 1'b1;
        expect_phase("t3g7", C_GREEN, 7, 7, 0);
        tl.pedestrian = 1'b0;
        expect_phase("t3a",  C_AMBER, 0, 3, 1);

        // 4: pedestrian held throughout RED is ignored
        tl.pedestrian = 1'b1;
        expect_phase("t4r",  C_RED,   0, 9, 0);
        tl.pedestrian = 1'b0;
        expect_phase("t4g",  C_GREEN, 0, 7, 0);
        expect_phase("t4a",  C_AMBER, 0, 3, 0);

        // 5: reset at GREEN count 4 with a pending request
        expect_phase("t5r0", C_RED,   0, 9, 0);
        expect_phase("t5g",  C_GREEN, 0, 2, 0);
        tl.pedestrian = 1'b1;
        expect_phase("t5g3", C_GREEN, 3, 3, 0);
        tl.pedestrian = 1'b0;
        rst = 1'b1;
        expect_phase("t5g4", C_GREEN, 4, 4, 1);
        rst = 1'b0;
        expect_phase("t5r",  C_RED,   0, 9, 0);

        // 6: pedestrian held -> 10/3/4 steady state
        tl.pedestrian = 1'b1;
        expect_phase("t6g0", C_GREEN, 0, 0, 0);
        expect_phase("t6g",  C_GREEN, 1, 2, 1);
        expect_phase("t6a",  C_AMBER, 0, 3, 1);
        expect_phase("t6r",  C_RED,   0, 9, 0);
        expect_phase("t6g0b", C_GREEN, 0, 0, 0);
        expect_phase("t6gb", C_GREEN, 1, 2, 1);
        expect_phase("t6ab", C_AMBER, 0, 3, 1);
        expect_phase("t6rb", C_RED,   0, 0, 0);
        tl.pedestrian = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
